// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer.
// Holds the microword field positions, the SEQ opcode encodings,
// the blanking constants for the display and a small decode helper.
package useq_pkg;

    // Microword field bit positions
    localparam int SEQ_HI  = 21;
    localparam int SEQ_LO  = 19;
    localparam int ADDR_HI = 18;
    localparam int ADDR_LO = 14;
    localparam int SEG_HI  = 13;
    localparam int SEG_LO  = 7;
    localparam int AN_HI   = 6;
    localparam int AN_LO   = 3;
    localparam int LED_HI  = 2;
    localparam int LED_LO  = 0;

    // SEQ opcodes
    localparam logic [2:0] SEQ_JMP   = 3'b000;
    localparam logic [2:0] SEQ_INC   = 3'b001;
    localparam logic [2:0] SEQ_BR0   = 3'b010;
    localparam logic [2:0] SEQ_BR1   = 3'b011;
    localparam logic [2:0] SEQ_BRN0  = 3'b100;
    localparam logic [2:0] SEQ_WAIT  = 3'b101;
    localparam logic [2:0] SEQ_WAITJ = 3'b110;
    localparam logic [2:0] SEQ_HALT  = 3'b111;

    // Display blanking values (active-low outputs)
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic is_wait_code(input logic [2:0] seq);
        return (seq == SEQ_WAIT) || (seq == SEQ_WAITJ);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, clears both stages to 0
//   d      - asynchronous input bus (each bit synchronized independently)
//   q      - synchronized output, two cycles of latency
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/useq_secuenciador.sv
// Microsequencer: holds the micro-program counter (uPC), addresses the
// combinational microprogram ROM and registers the returned microword
// onto the board display and status LEDs.
// Ports:
//   CLK      - system clock
//   RESET_N  - asynchronous active-low reset
//   COND     - asynchronous condition inputs, synchronized internally
//   MICRO    - microword returned by the ROM for the current DIR
//   PASO     - single-step button (only with USEQ_STEP_EN)
//   DIR      - ROM address, driven straight from uPC
//   SEG      - 7-segment pattern, active-low, registered
//   AN       - anode enables, active-low, registered
//   LED      - status field, registered
// Build option: define USEQ_STEP_EN to add PASO; uPC and the wait prescaler
// then advance only once per synchronized rising edge of PASO.
module useq_secuenciador
    import useq_pkg::*;
#(
    parameter int unsigned AW  = 5,
    parameter int unsigned DW  = 22,
    parameter int unsigned DIV = 50000000
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [1:0]    COND,
    input  logic [DW-1:0] MICRO,
`ifdef USEQ_STEP_EN
    input  logic          PASO,
`endif
    output logic [AW-1:0] DIR,
    output logic [6:0]    SEG,
    output logic [3:0]    AN,
    output logic [2:0]    LED
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [AW-1:0] upc_q, upc_d, upc_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cs;
    logic          step;
    logic          tick;
    logic          in_wait;
    logic [2:0]    seq;
    logic [AW-1:0] addr;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [2:0]    led_q;

    assign seq  = MICRO[SEQ_HI:SEQ_LO];
    assign addr = MICRO[ADDR_HI:ADDR_LO];

    sync_2ff #(
        .W (2)
    ) u_cond_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (COND),
        .q     (cs)
    );

`ifdef USEQ_STEP_EN
    logic paso_s;
    logic paso_prev;
    logic pulse_q;

    sync_2ff #(
        .W (1)
    ) u_paso_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (PASO),
        .q     (paso_s)
    );

    // Registered rising-edge detect: one step per press
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            paso_prev <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            paso_prev <= paso_s;
            pulse_q   <= paso_s & ~paso_prev;
        end
    end

    assign step = pulse_q;
`else
    assign step = 1'b1;
`endif

    assign upc_inc = upc_q + AW'(1);
    assign tick    = (cnt_q == CNT_LAST);
    assign in_wait = is_wait_code(seq);

    // Next-address selection
    always_comb begin
        upc_d = upc_q;
        if (step) begin
            case (seq)
                SEQ_JMP:   upc_d = addr;
                SEQ_INC:   upc_d = upc_inc;
                SEQ_BR0:   upc_d = cs[0] ? addr : upc_inc;
                SEQ_BR1:   upc_d = cs[1] ? addr : upc_inc;
                SEQ_BRN0:  upc_d = !cs[0] ? addr : upc_inc;
                SEQ_WAIT:  upc_d = tick ? upc_inc : upc_q;
                SEQ_WAITJ: upc_d = tick ? addr : upc_q;
                SEQ_HALT:  upc_d = upc_q;
                default:   upc_d = upc_q;
            endcase
        end
    end

    // Prescaler: runs only under a wait code; a wait advances exactly on tick,
    // so clearing on tick also clears it on the cycle uPC moves (and keeps a
    // WAITJ self-loop from overrunning DIV-1).
    always_comb begin
        cnt_d = cnt_q;
        if (!in_wait) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            upc_q <= '0;
            cnt_q <= '0;
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
        end
    end

    // Display fields follow the word at DIR one cycle later, every cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
            led_q <= 3'b000;
        end else begin
            seg_q <= MICRO[SEG_HI:SEG_LO];
            an_q  <= MICRO[AN_HI:AN_LO];
            led_q <= MICRO[LED_HI:LED_LO];
        end
    end

    assign DIR = upc_q;
    assign SEG = seg_q;
    assign AN  = an_q;
    assign LED = led_q;

endmodule

// File: doc/useq_secuenciador.md
Name: useq_secuenciador

Overview:
- Microsequencer that drives the 5-bit microprogram memory and registers its 22-bit microword onto display and status outputs.
- Holds the micro-program counter (uPC) and decodes the sequence field to select the next address: increment, jump, conditional branch, timed wait or halt.
- Sits between the microprogram ROM (combinational, address in / word out) and the board display: 7-seg, anodes, status LEDs.

Parameters:
- AW, 5, microprogram address width.
- DW, 22, microword width.
- DIV, 50000000, clock cycles per WAIT instruction; minimum 2.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- COND  in  2  asynchronous condition inputs (buttons/sensors).
- MICRO  in  DW  microword returned by the ROM for the current DIR.
- DIR  out  AW  ROM address; equals uPC.
- SEG  out  7  segment pattern, active-low.
- AN  out  4  anode enables, active-low.
- LED  out  3  status field.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Microword fields:
  - [21:19] SEQ.
  - [18:14] ADDR.
  - [13:7] SEG.
  - [6:3] AN.
  - [2:0] LED.
- Reset values:
  - uPC = 0, so DIR = 0.
  - SEG = 7'b1111111.
  - AN = 4'b1111.
  - LED = 3'b000.
  - Prescaler = 0.
  - Synchronizer flops = 0.
- DIR is driven directly from the uPC register. MICRO is valid in the same cycle.
- SEG/AN/LED are registered from MICRO every cycle, one cycle after DIR.
- COND passes through a 2-flop synchronizer (cs). Branches use cs, so latency from a COND change to its use is 2 cycles.
- SEQ decode (next uPC):
  - 000 JMP: ADDR.
  - 001 INC: uPC+1; wraps 31 -> 0.
  - 010 BR0: cs[0] ? ADDR : uPC+1.
  - 011 BR1: cs[1] ? ADDR : uPC+1.
  - 100 BRN0: !cs[0] ? ADDR : uPC+1.
  - 101 WAIT: tick ? uPC+1 : uPC.
  - 110 WAITJ: tick ? ADDR : uPC.
  - 111 HALT: uPC held; exit only by reset.
- Prescaler:
  - Counts only while SEQ is WAIT or WAITJ.
  - Cleared to 0 on any cycle where SEQ is not a wait code, and on the cycle uPC changes.
  - tick = (cnt == DIV-1).
  - A wait instruction therefore occupies exactly DIV cycles.
  - Back-to-back waits each take DIV cycles, because the counter is cleared on the advance.
- Boundaries:
  - INC/BRx fall-through at address 31 wraps to 0.
  - A branch with ADDR == uPC forms a self-loop that re-evaluates cs every cycle.
  - Reset mid-wait clears the prescaler, returns DIR to 0 immediately (asynchronous) and blanks the outputs.
  - COND changes during WAIT are ignored.
  - Outputs keep updating during HALT and WAIT; they track the held word.

Optional Feature:
- USEQ_STEP_EN, with an added input PASO (1 bit, asynchronous).
- Defined:
  - PASO is synchronized with 2 flops, and a rising edge produces a one-cycle pulse.
  - uPC and the prescaler advance only on cycles with that pulse, so the machine executes one microinstruction per PASO press.
  - A WAIT then requires DIV pulses.
  - SEG/AN/LED still update every cycle.
- Undefined: PASO port absent; the machine advances every cycle.

Decomposition:
- Package useq_pkg:
  - Field bit positions (SEQ_HI/LO, ADDR_HI/LO, SEG_HI/LO, AN_HI/LO, LED_HI/LO).
  - SEQ opcode localparams (SEQ_JMP, SEQ_INC, SEQ_BR0, SEQ_BR1, SEQ_BRN0, SEQ_WAIT, SEQ_WAITJ, SEQ_HALT).
  - Blank constants SEG_OFF = 7'h7F, AN_OFF = 4'hF.
- One sub-module sync_2ff (parameter W, asynchronous active-low reset), instantiated for COND and, with USEQ_STEP_EN, for PASO.
- Prescaler, next-address mux and output registers live in the top level.

Test Plan:
- Reset:
  - Stimulus: assert RESET_N=0 mid-run; release on a clock edge.
  - Response: DIR=0 and SEG=7F, AN=F, LED=0 while reset is asserted. One cycle after release, SEG/AN/LED equal word[0] fields.
- INC chain and wrap:
  - Stimulus: ROM all SEQ=001.
  - Response: DIR runs 0,1,…,31,0, one step per cycle.
- Branch:
  - Stimulus: word 3 = BR0, ADDR=20. COND[0]=1 held 3 cycles, then run.
  - Response: DIR goes 3 -> 20.
  - Stimulus: COND[0]=0.
  - Response: DIR goes 3 -> 4.
  - Stimulus: COND[0] toggled 1 cycle before reaching word 3.
  - Response: old value used (2-cycle sync).
- Wait timing:
  - Stimulus: DIV=4; word 5 = WAIT, word 6 = WAITJ with ADDR=0.
  - Response: DIR=5 for exactly 4 cycles, then DIR=6 for 4 cycles, then DIR=0.
- Halt and reset mid-wait:
  - Stimulus: word 2 = HALT.
  - Response: DIR stays 2 for 100 cycles.
  - Stimulus: pulse RESET_N during a WAIT at cycle 2 of 4.
  - Response: DIR=0; the next WAIT takes a full 4 cycles.
- USEQ_STEP_EN:
  - Stimulus: all INC; apply 3 PASO pulses spaced 10 cycles apart.
  - Response: DIR = 0 -> 1 -> 2 -> 3 only, each change 3 cycles after the PASO rise.
